// File: rtl/parity_pkg.sv
// Shared types and helpers for the odd/even parity link (receive checker and transmit-side models).
// The optional error counter width lives here; the counter itself is enabled by PARITY_ERR_CNT_EN.
package parity_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int ERR_CNT_W  = 8;
  localparam int FOLD_MAX_W = 16;

  // Parity bit that makes (data ones + parity bit) odd when odd=1, even when odd=0.
  function automatic logic parity_fold(input logic [FOLD_MAX_W-1:0] data,
                                       input int width, input logic odd);
    logic acc;
    acc = odd;
    for (int i = 0; i < FOLD_MAX_W; i++)
      if (i < width) acc ^= data[i];
    return acc;
  endfunction

endpackage

// File: rtl/parity_accum.sv
// Running XOR of the data bits seen so far in the current frame.
module parity_accum (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic par
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   par <= 1'b0;
    else if (clr) par <= 1'b0;
    else if (en)  par <= par ^ bit_in;
  end

endmodule

// File: rtl/serial_parity_checker.sv
// Receive side of the parity link: deserialises start/data/parity/stop frames, flags parity and framing errors.
// Define PARITY_ERR_CNT_EN to add the saturating err_cnt output.
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int   CNT_W    = $clog2(DATA_W + 1);
  localparam logic ODD      = 1'(ODD_PARITY);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state, state_n;
  logic [DATA_W-1:0] sreg;
  logic [CNT_W-1:0]  cnt;
  logic              par;
  logic              mismatch;
  logic              start, shift, chk, done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // clr outranks bit_valid; without a qualified bit nothing advances.
  always_comb begin
    state_n = state;
    start   = 1'b0;
    shift   = 1'b0;
    chk     = 1'b0;
    done    = 1'b0;
    if (clr) begin
      state_n = IDLE;
    end else if (bit_valid) begin
      case (state)
        IDLE:   if (!bit_in) begin
                  state_n = DATA;
                  start   = 1'b1;
                end
        DATA:   begin
                  shift = 1'b1;
                  if (cnt == LAST_BIT) state_n = PARITY;
                end
        PARITY: begin
                  chk     = 1'b1;
                  state_n = STOP;
                end
        STOP:   begin
                  done    = 1'b1;
                  state_n = IDLE;
                end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  parity_accum u_accum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr | start),
    .en     (shift),
    .bit_in (bit_in),
    .par    (par)
  );

  // LSB arrives first, so shifting in at the MSB leaves the word aligned after DATA_W bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg       <= '0;
      cnt        <= '0;
      mismatch   <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= done;
      if (clr) begin
        cnt <= '0;
      end else if (start) begin
        cnt  <= '0;
        sreg <= '0;
      end else if (shift) begin
        sreg <= {bit_in, sreg[DATA_W-1:1]};
        cnt  <= cnt + 1'b1;
      end
      if (chk) mismatch <= (bit_in != (par ^ ODD));
      if (done) begin
        data_out   <= sreg;
        parity_err <= mismatch;
        frame_err  <= ~bit_in;
      end
    end
  end

`ifdef PARITY_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (clr)
      err_cnt <= '0;
    else if (done && (mismatch || !bit_in) && (err_cnt != {ERR_CNT_W{1'b1}}))
      err_cnt <= err_cnt + 1'b1;
  end
`endif

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Receive end of the team's odd-parity link: deserialises a start/data/parity/stop frame presented one bit per qualified clock.
- Recomputes parity incrementally and flags parity and framing errors.
- Sits behind the XNOR-chain parity generator on the transmit side and hands parallel words to downstream logic.

Parameters:
- DATA_W, 8, number of data bits per frame (legal range 2..16).
- ODD_PARITY, 1, 1 = odd parity (total ones across data plus parity is odd); 0 = even parity.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous abort; returns the FSM to IDLE and discards the partial frame.
- bit_in  input  1  serial line bit; sampled only when bit_valid=1.
- bit_valid  input  1  qualifies bit_in for this cycle.
- data_out  output  DATA_W  received word, LSB first on the line.
- data_valid  output  1  one-cycle pulse; frame complete.
- parity_err  output  1  parity mismatch for the frame; valid with data_valid.
- frame_err  output  1  stop bit was 0; valid with data_valid.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; data_out=0; data_valid=0; parity_err=0; frame_err=0; busy=0; bit counter=0; running parity=0.
- All state advances occur only on cycles with bit_valid=1. Cycles with bit_valid=0 hold all state, and data_valid is forced to 0.
- FSM states and transitions:
  - IDLE: bit_in=0 (start bit) goes to DATA, clears the shift register, counter and running parity. bit_in=1 stays in IDLE (line idle high).
  - DATA: shifts bit_in in at the MSB of the shift register, so the LSB-first stream ends aligned. Increments the counter and updates running parity as parity ^= bit_in. After the DATA_W-th bit, goes to PARITY.
  - PARITY: computes expected = running parity ^ ODD_PARITY, i.e. an XNOR fold when odd. Latches mismatch = (bit_in != expected). Goes to STOP.
  - STOP: latches data_out=shift register, parity_err=mismatch and frame_err=~bit_in. Pulses data_valid for exactly that one cycle (registered, visible the cycle after the stop bit is sampled). Goes to IDLE.
- Latency: data_valid rises 1 clk after the qualified stop-bit edge.
- data_out, parity_err and frame_err hold their values until the next frame completes. They are not cleared when data_valid drops.
- data_valid is asserted even when an error flag is set; the flags qualify the word.
- A start bit sampled in the same cycle data_valid is high is accepted. Back-to-back frames with no idle bits are legal.
- clr=1 has priority over bit_valid: the FSM returns to IDLE and counter/parity clear. Outputs data_out and the flags keep their last values, and data_valid=0 that cycle.
- rst_n asserted mid-frame: immediate return to the reset values; no partial word is emitted.
- Counter width is $clog2(DATA_W+1). There is no wrap: the counter compares against DATA_W-1 and exits DATA.

Optional Feature:
- Macro PARITY_ERR_CNT_EN.
- When defined: adds output err_cnt [7:0], a saturating count of frames completed with parity_err or frame_err. It resets to 0, stops at 255, and clears on clr.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package parity_pkg holds:
  - state enum typedef (IDLE, DATA, PARITY, STOP);
  - localparam ERR_CNT_W=8;
  - function parity_fold(width-generic XOR reduction with odd/even select), reused by the generator-side model in benches.
- One natural sub-module: parity_accum, which holds the running parity register with clear, enable and bit inputs. The FSM, shift register and counter stay in the top.

Test Plan:
- DATA_W=8, ODD_PARITY=1; stream 0, LSB-first 0xA5, parity 1, stop 1 -> data_out=0xA5, data_valid pulse, parity_err=0, frame_err=0.
- Same frame with parity bit 0 -> data_out=0xA5, parity_err=1, frame_err=0; with err_cnt enabled, err_cnt=1.
- 0x07 with parity 0, stop 0 -> parity_err=0, frame_err=1.
- Two frames back-to-back, 0x3C then 0xFF (parity bits 1,1), bit_valid toggling 1/0 each cycle -> two data_valid pulses with correct words and no extra pulses.
- clr asserted after 4 data bits, then full 0x5A frame -> only 0x5A is reported; prior data_out is unchanged until then.
- rst_n pulsed low mid-DATA -> all outputs 0 asynchronously; the next full frame decodes correctly.
